fetch_unit: RTL

- Instruction-fetch stage directly upstream of the decoder.
- Owns the program counter and drives the synchronous-read program memory address. Presents each fetched instruction word and its PC to the decoder.
- Redirects on jumps resolved downstream and generates the pipeline flush for wrong-path words. Supports a hold (stall) request.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encodings and the NOP bubble word.
package fetch_unit_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_BOOT  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_FLUSH = 2'd2;

    // All-zero word is decoded as a bubble downstream.
    localparam logic [15:0] NOP_WORD = 16'h0000;

    // Width of a down-counter that must hold n-1 for n >= 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the synchronous program-memory address,
// presents word+PC to the decoder and flushes wrong-path words after a jump.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PMEM_ADDR_WIDTH = 12,
    parameter int unsigned PMEM_WORD_WIDTH = 16,
    parameter int unsigned PC_WIDTH        = 12,
    parameter int unsigned RESET_PC        = 0,
    parameter int unsigned FLUSH_CYCLES    = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_stall,
    input  logic                       in_jump,
    input  logic [PC_WIDTH-1:0]        in_jump_target,
    input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_data,
    output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic                       out_flush
);

    localparam int unsigned CNT_W       = cnt_width(FLUSH_CYCLES);
    localparam bit          MULTI_FLUSH = (FLUSH_CYCLES > 1);

    localparam logic [PC_WIDTH-1:0] PC_RST   = PC_WIDTH'(RESET_PC);
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 1 : 0);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_fetched_q, pc_fetched_d;
    logic [STATE_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    // Jump is masked while reset is held so outputs show pure reset values.
    logic jump_take;
    assign jump_take = in_jump & reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q         <= PC_RST;
            pc_fetched_q <= PC_RST;
            state_q      <= ST_BOOT;
            flush_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            pc_fetched_q <= pc_fetched_d;
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        pc_fetched_d = pc_fetched_q;
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;

        if (jump_take) begin
            pc_fetched_d = in_jump_target;
            pc_d         = in_jump_target + PC_WIDTH'(1);
            if (MULTI_FLUSH) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = CNT_LOAD;
            end else begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end
        end else if (in_stall) begin
            // Hold everything, including BOOT, so no word is presented twice.
            state_d = state_q;
        end else begin
            case (state_q)
                ST_BOOT, ST_RUN: begin
                    pc_fetched_d = pc_q;
                    pc_d         = pc_q + PC_WIDTH'(1);
                    state_d      = ST_RUN;
                end
                ST_FLUSH: begin
                    if (flush_cnt_q <= CNT_W'(1)) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d      = ST_BOOT;
                    flush_cnt_d  = '0;
                    pc_d         = PC_RST;
                    pc_fetched_d = PC_RST;
                end
            endcase
        end
    end

    // During FLUSH the target (held in pc_fetched) is re-read so it is valid on exit.
    logic [PC_WIDTH-1:0] addr_sel;
    always_comb begin
        addr_sel = pc_q;
        if (jump_take) begin
            addr_sel = in_jump_target;
        end else if (in_stall || (state_q == ST_FLUSH)) begin
            addr_sel = pc_fetched_q;
        end
    end

    assign out_pmem_addr = PMEM_ADDR_WIDTH'(addr_sel);
    assign out_pc        = pc_fetched_q;
    assign out_flush     = jump_take | (state_q == ST_FLUSH);
    assign out_instr     = ((state_q == ST_RUN) && !out_flush)
                           ? in_pmem_data : PMEM_WORD_WIDTH'(NOP_WORD);

endmodule
